// File: rtl/dct_xpose_ctrl.sv
// -----------------------------------------------------------------------------
// dct_xpose_ctrl
//
// Ping-pong 4x4 transpose buffer between the row-DCT and column-DCT passes.
// Row results arrive as 4-coefficient beats (one row per beat, four beats per
// block) and are written into one bank. The other bank is drained column-wise,
// again as 4-coefficient beats. Both sides use valid/ready handshakes and each
// bank carries an explicit state (EMPTY, FILLING, FULL, DRAINING).
//
// Parameters
//   DW          coefficient width in bits (default 36)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous, active-low reset
//   in_valid    row beat valid
//   in_ready    row beat accepted when in_valid && in_ready
//   in_d0..3    row coefficients, column index 0..3
//   out_valid   column beat valid
//   out_ready   downstream accepts column beat
//   out_d0..3   column coefficients, row index 0..3 (zero while !out_valid)
//   out_col     column index of the current output beat
//   out_last    high with column 3 of a block
//   bank_full   bit b set while bank b holds a complete, undrained block
//   blk_count   completed-block counter
//
// Build option
//   DCT_XPOSE_BLKCNT_EN  when defined, blk_count is a 16-bit wrapping counter
//                        of out_last handshakes; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module dct_xpose_ctrl #(
  parameter int DW = 36
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_d0,
  input  logic [DW-1:0] in_d1,
  input  logic [DW-1:0] in_d2,
  input  logic [DW-1:0] in_d3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_d0,
  output logic [DW-1:0] out_d1,
  output logic [DW-1:0] out_d2,
  output logic [DW-1:0] out_d3,
  output logic [1:0]    out_col,
  output logic          out_last,
  output logic [1:0]    bank_full,
  output logic [15:0]   blk_count
);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_st_t;

  bank_st_t      st_q [2];
  bank_st_t      st_n [2];
  logic          wr_bank_q, wr_bank_n;
  logic [1:0]    wr_row_q,  wr_row_n;
  logic          rd_bank_q, rd_bank_n;
  logic [1:0]    rd_col_q,  rd_col_n;
  logic          vld_q,     vld_n;

  logic          wr_fire, wr_done;
  logic          rd_fire, rd_done;

  // Coefficient storage: mem[bank][row][col]. Not reset; the bank state
  // machine guarantees only fully written blocks are ever read.
  logic [DW-1:0] mem [2][4][4];

  // in_ready looks only at registered bank state, so a bank freed on this
  // edge becomes writable on the following cycle. It is forced low while
  // reset is held.
  assign in_ready = rst && ((st_q[wr_bank_q] == ST_EMPTY) ||
                            (st_q[wr_bank_q] == ST_FILLING));

  assign wr_fire = in_valid && in_ready;
  assign wr_done = wr_fire && (wr_row_q == 2'd3);
  assign rd_fire = vld_q && out_ready;
  assign rd_done = rd_fire && (rd_col_q == 2'd3);

  // ---------------------------------------------------------------------------
  // Next-state: bank states, write pointers, read pointers, output valid
  // ---------------------------------------------------------------------------
  always_comb begin
    st_n[0]   = st_q[0];
    st_n[1]   = st_q[1];
    wr_bank_n = wr_bank_q;
    wr_row_n  = wr_row_q;
    rd_bank_n = rd_bank_q;
    rd_col_n  = rd_col_q;
    vld_n     = vld_q;

    if (wr_fire) begin
      wr_row_n = wr_row_q + 2'd1;
      if (wr_done) begin
        st_n[wr_bank_q] = ST_FULL;
        wr_bank_n       = ~wr_bank_q;
      end else begin
        st_n[wr_bank_q] = ST_FILLING;
      end
    end

    if (rd_fire) begin
      rd_col_n = rd_col_q + 2'd1;
      if (rd_done) begin
        st_n[rd_bank_q] = ST_EMPTY;
        rd_bank_n       = ~rd_bank_q;
        vld_n           = 1'b0;
      end
    end

    // Launch a drain from the post-update view of the bank the read side
    // will point at. This lets a block that completes on this very edge
    // start draining immediately, and lets a block that became full while
    // the other bank was draining follow the out_last beat with no bubble.
    if (!vld_n && (st_n[rd_bank_n] == ST_FULL)) begin
      st_n[rd_bank_n] = ST_DRAINING;
      vld_n           = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q[0]   <= ST_EMPTY;
      st_q[1]   <= ST_EMPTY;
      wr_bank_q <= 1'b0;
      wr_row_q  <= 2'd0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= 2'd0;
      vld_q     <= 1'b0;
    end else begin
      st_q[0]   <= st_n[0];
      st_q[1]   <= st_n[1];
      wr_bank_q <= wr_bank_n;
      wr_row_q  <= wr_row_n;
      rd_bank_q <= rd_bank_n;
      rd_col_q  <= rd_col_n;
      vld_q     <= vld_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage write
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank_q][wr_row_q][0] <= in_d0;
      mem[wr_bank_q][wr_row_q][1] <= in_d1;
      mem[wr_bank_q][wr_row_q][2] <= in_d2;
      mem[wr_bank_q][wr_row_q][3] <= in_d3;
    end
  end

  // ---------------------------------------------------------------------------
  // Column read-out
  // ---------------------------------------------------------------------------
  // The draining bank is never writable, and rd_col only moves on a
  // handshake, so these stay stable while out_ready is held low.
  assign out_valid = vld_q;
  assign out_col   = rd_col_q;
  assign out_last  = vld_q && (rd_col_q == 2'd3);
  assign out_d0    = vld_q ? mem[rd_bank_q][0][rd_col_q] : '0;
  assign out_d1    = vld_q ? mem[rd_bank_q][1][rd_col_q] : '0;
  assign out_d2    = vld_q ? mem[rd_bank_q][2][rd_col_q] : '0;
  assign out_d3    = vld_q ? mem[rd_bank_q][3][rd_col_q] : '0;

  assign bank_full[0] = (st_q[0] == ST_FULL) || (st_q[0] == ST_DRAINING);
  assign bank_full[1] = (st_q[1] == ST_FULL) || (st_q[1] == ST_DRAINING);

`ifdef DCT_XPOSE_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt_q <= 16'h0000;
    end else if (rd_done) begin
      blk_cnt_q <= blk_cnt_q + 16'h0001;
    end
  end

  assign blk_count = blk_cnt_q;
`else
  assign blk_count = 16'h0000;
`endif

endmodule
